// File: rtl/led_controller_pkg.sv
// Shared constants for the memory-mapped I/O blocks: memory map, FSM encoding
// and duty field width.
package led_controller_pkg;

    localparam int MEM_DEPTH        = 8192;
    localparam int LED_ADDR_DEFAULT = 7808;
    localparam int BUTTON_ADDR      = 7824;
    localparam int DUTY_W           = 8;

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Index width for a channel count; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// One PWM output channel: holds the committed duty and compares it against
// the shared free-running counter.
module led_pwm
    import led_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DUTY_W-1:0] shadow_duty,
    input  logic [DUTY_W-1:0] pwm_cnt,
    output logic              led_out
);

    logic [DUTY_W-1:0] r_duty;

    // Committed duty register, loaded from the shadow value on commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty <= 8'd0;
        end else if (load) begin
            r_duty <= shadow_duty;
        end else begin
            r_duty <= r_duty;
        end
    end

    // Full scale is forced on so 0xFF never shows the one-cycle gap at count 255.
    assign led_out = (r_duty == 8'hFF) | (pwm_cnt < r_duty);

endmodule

// File: rtl/led_controller.sv
// Reads LED_COUNT duty words from data memory on each copy_start and commits
// them atomically to per-channel PWM outputs.
module led_controller
    import led_controller_pkg::*;
#(
    parameter int LED_COUNT  = 6,
    parameter int LED_ADDR   = LED_ADDR_DEFAULT,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  copy_start,
    output logic                  mem_din_re,
    output logic [ADDR_WIDTH-1:0] mem_din_addr,
    input  logic [15:0]           mem_din,
    output logic [LED_COUNT-1:0]  leds_out,
    output logic                  copy_done
);

    localparam int                    IDX_W    = idx_width(LED_COUNT);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(LED_ADDR);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(LED_COUNT - 1);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [IDX_W-1:0]      r_rd_idx;
    logic                  r_pipe;
    logic [IDX_W-1:0]      r_cap_idx;
    logic [DUTY_W-1:0]     r_pwm_cnt;
    logic [DUTY_W-1:0]     r_shadow      [LED_COUNT];
    logic [DUTY_W-1:0]     w_shadow_next [LED_COUNT];
    logic                  w_load;
    logic                  w_unused_hi;

    // Refresh sequencer: issue N reads, drain the last word, flag completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_WAIT;
            r_addr   <= BASE;
            r_rd_idx <= {IDX_W{1'b0}};
        end else begin
            case (r_state)
                ST_WAIT: begin
                    r_addr   <= BASE;
                    r_rd_idx <= {IDX_W{1'b0}};
                    r_state  <= copy_start ? ST_READ : ST_WAIT;
                end
                ST_READ: begin
                    if (r_rd_idx == LAST_IDX) begin
                        r_addr   <= BASE;
                        r_rd_idx <= {IDX_W{1'b0}};
                        r_state  <= ST_DRAIN;
                    end else begin
                        r_addr   <= r_addr + 1'b1;
                        r_rd_idx <= r_rd_idx + 1'b1;
                        r_state  <= ST_READ;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_WAIT;
                end
                default: begin
                    r_state  <= ST_WAIT;
                    r_addr   <= BASE;
                    r_rd_idx <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // The commit reads the next-shadow view so the word landing in DRAIN is included.
    always_comb begin
        for (int i = 0; i < LED_COUNT; i++) begin
            if (r_pipe && (r_cap_idx == IDX_W'(i))) begin
                w_shadow_next[i] = mem_din[7:0];
            end else begin
                w_shadow_next[i] = r_shadow[i];
            end
        end
    end

    // Read-valid pipe, capture index and shadow buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe    <= 1'b0;
            r_cap_idx <= {IDX_W{1'b0}};
            for (int i = 0; i < LED_COUNT; i++) begin
                r_shadow[i] <= 8'd0;
            end
        end else begin
            r_pipe    <= (r_state == ST_READ);
            r_cap_idx <= r_rd_idx;
            for (int i = 0; i < LED_COUNT; i++) begin
                r_shadow[i] <= w_shadow_next[i];
            end
        end
    end

    // Shared free-running PWM counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= 8'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    assign w_load       = (r_state == ST_DRAIN);
    assign mem_din_re   = (r_state == ST_READ);
    assign mem_din_addr = r_addr;
    assign copy_done    = (r_state == ST_DONE);
    assign w_unused_hi  = ^mem_din[15:8];

    for (genvar g = 0; g < LED_COUNT; g++) begin : g_ch
        led_pwm u_ch (
            .clk         (clk),
            .reset       (reset),
            .load        (w_load),
            .shadow_duty (w_shadow_next[g]),
            .pwm_cnt     (r_pwm_cnt),
            .led_out     (leds_out[g])
        );
    end

endmodule
